// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared constants and state type for the 8-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

   localparam int NREQ = 8;
   localparam int IDXW = 3;
   localparam int ARB_TIMEOUT_DEFAULT = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// Module   : rr_pick8
// Brief    : Masked round-robin priority encoder (rotate, fixed-priority, rotate back).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   input  logic [NREQ-1:0] exclude,
   output logic            any,
   output logic [IDXW-1:0] idx,
   output logic [NREQ-1:0] onehot
);

   logic [NREQ-1:0]   w_masked;
   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [IDXW-1:0]   w_pos;

   assign w_masked = req & ~exclude;
   // Rotating right by ptr puts the highest-priority requester at bit 0.
   assign w_dbl    = {w_masked, w_masked} >> ptr;
   assign w_rot    = w_dbl[NREQ-1:0];

   always_comb begin
      w_pos = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_pos = IDXW'(i);
         end
      end
   end

   assign any    = |w_rot;
   assign idx    = w_pos + ptr;
   assign onehot = any ? (NREQ'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// Module   : rr_arbiter8
// Brief    : 8-requester round-robin arbiter with held grants and registered outputs.
//            Optional watchdog revocation enabled by macro ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter8
   import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
)
`endif
(
   input  logic            iClk,
   input  logic            iRst_n,
   input  logic [NREQ-1:0] iReq,
   output logic [NREQ-1:0] oGrant,
   output logic [IDXW-1:0] oGrantIdx,
   output logic            oGrantValid,
   output logic            oTimeout
);

   arb_state_t      r_state;
   arb_state_t      w_state_nx;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] w_grant_nx;
   logic [IDXW-1:0] r_idx;
   logic [IDXW-1:0] w_idx_nx;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] w_ptr_nx;
   logic            w_new_grant;
   logic            w_owner_req;
   logic            w_tmo_hit;
   logic [NREQ-1:0] w_exclude;
   logic            w_pick_any;
   logic [IDXW-1:0] w_pick_idx;
   logic [NREQ-1:0] w_pick_onehot;

   assign w_owner_req = iReq[r_idx];

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

   logic [7:0] r_cnt;
   logic       r_tmo;

   assign w_tmo_hit = (r_state == BUSY) && w_owner_req && (r_cnt == c_tmo_last);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_cnt <= '0;
         r_tmo <= 1'b0;
      end else begin
         r_tmo <= w_tmo_hit;
         if (w_new_grant) begin
            r_cnt <= '0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign oTimeout = r_tmo;
`else
   assign w_tmo_hit = 1'b0;
   assign oTimeout  = 1'b0;
`endif

   // A revoked owner must not win the arbitration that revokes it.
   assign w_exclude = w_tmo_hit ? r_grant : '0;

   rr_pick8 u_pick (
      .req     (iReq),
      .ptr     (r_ptr),
      .exclude (w_exclude),
      .any     (w_pick_any),
      .idx     (w_pick_idx),
      .onehot  (w_pick_onehot)
   );

   always_comb begin
      w_state_nx  = r_state;
      w_grant_nx  = r_grant;
      w_idx_nx    = r_idx;
      w_ptr_nx    = r_ptr;
      w_new_grant = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nx  = BUSY;
               w_grant_nx  = w_pick_onehot;
               w_idx_nx    = w_pick_idx;
               w_ptr_nx    = w_pick_idx + IDXW'(1);
               w_new_grant = 1'b1;
            end
         end
         BUSY: begin
            if (!w_owner_req || w_tmo_hit) begin
               if (w_pick_any) begin
                  w_grant_nx  = w_pick_onehot;
                  w_idx_nx    = w_pick_idx;
                  w_ptr_nx    = w_pick_idx + IDXW'(1);
                  w_new_grant = 1'b1;
               end else begin
                  w_state_nx = IDLE;
                  w_grant_nx = '0;
                  w_idx_nx   = '0;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
            w_idx_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_grant <= w_grant_nx;
         r_idx   <= w_idx_nx;
         r_ptr   <= w_ptr_nx;
      end
   end

   assign oGrant      = r_grant;
   assign oGrantIdx   = r_idx;
   assign oGrantValid = |r_grant;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// ============================================================================
// Module   : tb_rr_arbiter8
// Brief    : Self-checking bench for rr_arbiter8 (vector table, corner sequences, random vs model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_arbiter8;
   import arb_pkg::*;

   logic       iClk   = 1'b0;
   logic       iRst_n = 1'b0;
   logic [7:0] iReq   = 8'h00;
   logic [7:0] oGrant;
   logic [2:0] oGrantIdx;
   logic       oGrantValid;
   logic       oTimeout;

   int checks = 0;
   int errors = 0;

   // Reference model: owner (-1 when idle), pointer, hold cycles, timeout pulse
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   bit m_tmo   = 1'b0;

   typedef struct {
      logic [7:0] req;
      logic [7:0] grant;
      logic [2:0] idx;
      logic       valid;
   } vec_t;

   vec_t tbl [13];

   always #5 iClk = ~iClk;

   rr_arbiter8 dut (
      .iClk        (iClk),
      .iRst_n      (iRst_n),
      .iReq        (iReq),
      .oGrant      (oGrant),
      .oGrantIdx   (oGrantIdx),
      .oGrantValid (oGrantValid),
      .oTimeout    (oTimeout)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int search(input logic [7:0] req, input int ptr, input int excl);
      for (int k = 0; k < 8; k++) begin
         int c;
         c = (ptr + k) % 8;
         if (req[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic model_grant(input int w);
      m_owner = w;
      m_ptr   = (w + 1) % 8;
      m_cnt   = 0;
   endtask

   task automatic model_step(input logic [7:0] req);
      int  w;
      bit  hit;
      m_tmo = 1'b0;
      if (m_owner < 0) begin
         w = search(req, m_ptr, -1);
         if (w >= 0) model_grant(w);
      end else begin
`ifdef ARB_TIMEOUT_EN
         hit = (m_cnt == ARB_TIMEOUT_DEFAULT - 1) && req[m_owner];
`else
         hit = 1'b0;
`endif
         if (req[m_owner] && !hit) begin
            m_cnt++;
         end else begin
            m_tmo = hit;
            w = search(req, m_ptr, hit ? m_owner : -1);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
         end
      end
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".grant"}, {24'd0, oGrant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk({tag, ".idx"},   {29'd0, oGrantIdx}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk({tag, ".valid"}, {31'd0, oGrantValid}, (m_owner < 0) ? 32'd0 : 32'd1);
      chk({tag, ".tmo"},   {31'd0, oTimeout}, {31'd0, m_tmo});
   endtask

   task automatic apply(input logic [7:0] req, input string tag);
      iReq = req;
      @(posedge iClk);
      model_step(req);
      #1;
      model_check(tag);
   endtask

   // Asserts reset away from any clock edge and checks outputs clear at once.
   task automatic do_reset();
      #2;
      iRst_n = 1'b0;
      iReq   = 8'h00;
      #1;
      chk("rst.grant", {24'd0, oGrant}, 32'd0);
      chk("rst.idx",   {29'd0, oGrantIdx}, 32'd0);
      chk("rst.valid", {31'd0, oGrantValid}, 32'd0);
      chk("rst.tmo",   {31'd0, oTimeout}, 32'd0);
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_tmo   = 1'b0;
      @(negedge iClk);
      iRst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] r;
      int n3, pulses, first6;

      tbl[0]  = '{8'h00, 8'h00, 3'd0, 1'b0};
      tbl[1]  = '{8'h08, 8'h08, 3'd3, 1'b1};
      tbl[2]  = '{8'h08, 8'h08, 3'd3, 1'b1};
      tbl[3]  = '{8'h0C, 8'h08, 3'd3, 1'b1};
      tbl[4]  = '{8'h04, 8'h04, 3'd2, 1'b1};
      tbl[5]  = '{8'h00, 8'h00, 3'd0, 1'b0};
      tbl[6]  = '{8'h81, 8'h80, 3'd7, 1'b1};
      tbl[7]  = '{8'h01, 8'h01, 3'd0, 1'b1};
      tbl[8]  = '{8'h14, 8'h04, 3'd2, 1'b1};
      tbl[9]  = '{8'h10, 8'h10, 3'd4, 1'b1};
      tbl[10] = '{8'h14, 8'h10, 3'd4, 1'b1};
      tbl[11] = '{8'h04, 8'h04, 3'd2, 1'b1};
      tbl[12] = '{8'h00, 8'h00, 3'd0, 1'b0};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         apply(tbl[i].req, "tbl");
         chk($sformatf("tbl%0d.grant", i), {24'd0, oGrant}, {24'd0, tbl[i].grant});
         chk($sformatf("tbl%0d.idx", i),   {29'd0, oGrantIdx}, {29'd0, tbl[i].idx});
         chk($sformatf("tbl%0d.valid", i), {31'd0, oGrantValid}, {31'd0, tbl[i].valid});
      end

      // Full round robin with no idle bubble between owners
      do_reset();
      apply(8'hFF, "rr");
      chk("rr.first", {29'd0, oGrantIdx}, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         apply(8'hFF, "rr");
         r = 8'hFF;
         r[(k - 1) % 8] = 1'b0;
         apply(r, "rr");
         chk($sformatf("rr%0d.idx", k), {29'd0, oGrantIdx}, 32'(k % 8));
         chk($sformatf("rr%0d.valid", k), {31'd0, oGrantValid}, 32'd1);
      end

      // Reset in the middle of a grant to owner 5, then stay idle
      do_reset();
      apply(8'h20, "mid");
      apply(8'h20, "mid");
      chk("mid.idx", {29'd0, oGrantIdx}, 32'd5);
      do_reset();
      for (int c = 0; c < 10; c++) begin
         apply(8'h00, "idle");
         chk("idle.valid", {31'd0, oGrantValid}, 32'd0);
      end

      // Owner 3 holds with requester 6 waiting
      do_reset();
      n3 = 0;
      pulses = 0;
      first6 = -1;
      for (int c = 0; c < 40; c++) begin
         apply(8'h48, "hold");
         if (first6 < 0 && oGrantValid && oGrantIdx == 3'd6) first6 = c;
         if (first6 < 0 && oGrantValid && oGrantIdx == 3'd3) n3++;
         if (oTimeout && c < 24) pulses++;
      end
`ifdef ARB_TIMEOUT_EN
      chk("hold.cycles3", 32'(n3), 32'd16);
      chk("hold.pulses",  32'(pulses), 32'd1);
`else
      chk("hold.cycles3", 32'(n3), 32'd40);
      chk("hold.pulses",  32'(pulses), 32'd0);
`endif

      // Random traffic against the model; owners tend to keep requesting
      do_reset();
      r = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         else if (m_owner >= 0 && $urandom_range(0, 5) == 0) r[m_owner] = 1'b0;
         apply(r, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
